// File: rtl/demux4_pkg.sv
// Shared definitions for the four-lane stream demultiplexer: lane count,
// lane index width, per-lane buffer state and the mode encodings.
package demux4_pkg;

    localparam int LANES      = 4;
    localparam int LANE_IDX_W = 2;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux4_lane.sv
// One-entry output buffer for a single lane. A load and a drain in the same
// cycle replace the held word without a bubble.
module demux4_lane
    import demux4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              can_load
);

    lane_state_t       state;
    lane_state_t       state_next;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A load wins over a drain, so simultaneous drain+load keeps the lane full.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = FULL;
        end else if (state == FULL && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = data_q;
    assign can_load  = (state == EMPTY) || out_ready;

endmodule

// File: rtl/demux4_stream.sv
// Four-lane stream demultiplexer: routes each accepted input word to one lane
// chosen by explicit select or a round-robin pointer.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [LANE_IDX_W-1:0]   in_sel,
    input  logic                    mode,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANE_IDX_W-1:0]   rr_ptr,
    output logic [7:0]              xfer_cnt
);

    logic [LANE_IDX_W-1:0] target;
    logic [LANES-1:0]      lane_load;
    logic [LANES-1:0]      lane_can_load;
    logic                  xfer;

    assign target   = (mode == MODE_SEL) ? in_sel : rr_ptr;
    assign in_ready = lane_can_load[target];
    assign xfer     = in_valid && in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_load[g] = xfer && (target == LANE_IDX_W'(g));

        demux4_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (lane_load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*DATA_W +: DATA_W]),
            .can_load  (lane_can_load[g])
        );
    end

    // The pointer only moves on round-robin transfers, so switching modes never disturbs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            xfer_cnt <= '0;
        end else if (xfer) begin
            xfer_cnt <= xfer_cnt + 8'd1;
            if (mode == MODE_RR) begin
                rr_ptr <= rr_ptr + LANE_IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: a negedge monitor keeps per-lane
// expected-word queues and a reference model of rr_ptr, xfer_cnt and in_ready.
module tb_demux4_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          mode;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*DW-1:0] out_data;
    logic [1:0]    rr_ptr;
    logic [7:0]    xfer_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q [4][$];
    logic [1:0]    model_rr;
    logic [7:0]    model_cnt;

    demux4_stream #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .xfer_cnt  (xfer_cnt)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic md, input logic [DW-1:0] d);
        in_valid = v;
        in_sel   = sel;
        mode     = md;
        in_data  = d;
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Handshakes sampled mid-cycle are the ones the DUT commits on the next rising edge.
    always @(negedge clk) begin
        logic [1:0]    tgt;
        logic          model_ready;
        logic [DW-1:0] exp_word;
        if (rst) begin
            for (int i = 0; i < 4; i++) exp_q[i].delete();
            model_rr  = '0;
            model_cnt = '0;
        end else begin
            tgt         = mode ? model_rr : in_sel;
            model_ready = (exp_q[tgt].size() == 0) || out_ready[tgt];
            checkOutput("in_ready", in_ready, model_ready);
            checkOutput("rr_ptr", rr_ptr, model_rr);
            checkOutput("xfer_cnt", xfer_cnt, model_cnt);
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("out_valid[%0d]", i), out_valid[i], exp_q[i].size() != 0);
                if (exp_q[i].size() != 0) begin
                    checkOutput($sformatf("lane%0d_data", i), out_data[i*DW +: DW], exp_q[i][0]);
                    if (out_ready[i]) exp_word = exp_q[i].pop_front();
                end
            end
            if (in_valid && model_ready) begin
                exp_q[tgt].push_back(in_data);
                model_cnt = model_cnt + 8'd1;
                if (mode) model_rr = model_rr + 2'd1;
            end
        end
    end

    initial begin
        rst = 1'b1;
        out_ready = 4'b0000;
        applyStimulus(1'b0, 2'd0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 4'b0000);
        checkOutput("reset_rr_ptr", rr_ptr, 2'd0);
        checkOutput("reset_xfer_cnt", xfer_cnt, 8'd0);
        checkOutput("reset_out_data", out_data, 32'h0);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            checkOutput("in_ready_after_reset", in_ready, 1'b1);
        end

        // Single explicit-select word to lane 2.
        applyStimulus(1'b1, 2'd2, 1'b0, 8'hA5);
        wait_cycle();
        applyStimulus(1'b0, 2'd0, 1'b0, '0);
        checkOutput("sel_out_valid", out_valid, 4'b0100);
        checkOutput("sel_lane2_data", out_data[2*DW +: DW], 8'hA5);
        checkOutput("sel_xfer_cnt", xfer_cnt, 8'd1);

        // Round-robin burst of five words.
        out_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 2'd0, 1'b1, 8'(8'h10 + k));
            #1;
            checkOutput("rr_in_ready", in_ready, 1'b1);
            wait_cycle();
        end
        applyStimulus(1'b0, 2'd0, 1'b1, '0);
        checkOutput("rr_ptr_after_burst", rr_ptr, 2'd1);
        repeat (2) wait_cycle();

        // Blocked lane: lane 1 full and not ready.
        out_ready = 4'b0000;
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h11);
        wait_cycle();
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h99);
        #1;
        checkOutput("blocked_in_ready", in_ready, 1'b0);
        wait_cycle();
        checkOutput("blocked_lane1_data", out_data[1*DW +: DW], 8'h11);
        checkOutput("blocked_xfer_cnt", xfer_cnt, 8'd7);
        applyStimulus(1'b0, 2'd0, 1'b0, '0);

        // Same-cycle drain and reload of lane 3.
        applyStimulus(1'b1, 2'd3, 1'b0, 8'h33);
        wait_cycle();
        out_ready = 4'b1000;
        applyStimulus(1'b1, 2'd3, 1'b0, 8'h44);
        #1;
        checkOutput("reload_in_ready", in_ready, 1'b1);
        wait_cycle();
        applyStimulus(1'b0, 2'd0, 1'b0, '0);
        checkOutput("reload_out_valid3", out_valid[3], 1'b1);
        checkOutput("reload_lane3_data", out_data[3*DW +: DW], 8'h44);
        out_ready = 4'b1111;
        repeat (2) wait_cycle();

        // 256 transfers from a fresh reset wrap the counter back to zero.
        rst = 1'b1;
        wait_cycle();
        rst = 1'b0;
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0, 8'($urandom));
            wait_cycle();
        end
        applyStimulus(1'b0, 2'd0, 1'b0, '0);
        checkOutput("xfer_cnt_wrap", xfer_cnt, 8'd0);

        // Random traffic with mode switching and backpressure.
        for (int k = 0; k < 300; k++) begin
            out_ready = 4'($urandom);
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
            wait_cycle();
        end

        // Fill all lanes, then assert reset between clock edges.
        applyStimulus(1'b0, 2'd0, 1'b1, '0);
        out_ready = 4'b1111;
        repeat (2) wait_cycle();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'd0, 1'b1, 8'(8'hC0 + k));
            wait_cycle();
        end
        applyStimulus(1'b0, 2'd0, 1'b1, '0);
        checkOutput("full_before_reset", out_valid, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_out_valid", out_valid, 4'b0000);
        checkOutput("async_rr_ptr", rr_ptr, 2'd0);
        checkOutput("async_out_data", out_data, 32'h0);
        wait_cycle();
        rst = 1'b0;

        // Short burst and final drain: nothing left behind.
        for (int k = 0; k < 40; k++) begin
            out_ready = 4'($urandom);
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
            wait_cycle();
        end
        applyStimulus(1'b0, 2'd0, 1'b0, '0);
        out_ready = 4'b1111;
        repeat (3) wait_cycle();
        checkOutput("final_out_valid", out_valid, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("final_queue%0d", i), exp_q[i].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/demux4_stream.md
DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8: lane data width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  upstream word.
REQ-007 SHALL have port in_sel  input  2  destination lane when mode=0.
REQ-008 SHALL have port mode  input  1  0 = explicit select, 1 = round-robin.
REQ-009 SHALL have port out_valid  output  4  per-lane word present, bit i = lane i.
REQ-010 SHALL have port out_ready  input  4  per-lane consumer ready.
REQ-011 SHALL have port out_data  output  4*DATA_W  lane i on bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port rr_ptr  output  2  current round-robin lane.
REQ-013 SHALL have port xfer_cnt  output  8  count of accepted input words.

Function
REQ-014 Target lane SHALL be in_sel when mode=0 and rr_ptr when mode=1, evaluated combinationally each cycle.
REQ-015 Each lane SHALL hold a one-entry buffer (states EMPTY, FULL).
REQ-016 in_ready SHALL be 1 when the target lane is EMPTY, or is FULL with its out_ready=1 in the same cycle.
REQ-017 in_ready SHALL NOT depend on in_valid; a transfer occurs when in_valid and in_ready are both 1.
REQ-018 On transfer, the target lane SHALL load in_data and assert out_valid on the next cycle (latency 1).
REQ-019 Lane drain SHALL occur when out_valid[i] and out_ready[i] are both 1; the lane goes EMPTY next cycle unless reloaded.
REQ-020 Simultaneous drain and load on the same lane SHALL leave the lane FULL with the new word; no bubble.
REQ-021 Non-target lanes SHALL be unaffected by a transfer; every lane drains independently.
REQ-022 out_data[i] SHALL remain stable while out_valid[i]=1 and out_ready[i]=0.
REQ-023 out_data of an EMPTY lane SHALL keep its last loaded value; content is don't-care.
REQ-024 rr_ptr SHALL advance by 1 modulo 4 on each transfer while mode=1, wrapping 3 -> 0.
REQ-025 rr_ptr SHALL hold its value while mode=0 and on cycles with no transfer.
REQ-026 A mode change SHALL take effect in the same cycle; rr_ptr is not reset by a mode change.
REQ-027 xfer_cnt SHALL increment by 1 on each transfer, wrapping 255 -> 0.
REQ-028 A word SHALL never be dropped or duplicated; at most one lane is loaded per cycle.

Reset
REQ-029 While rst=1, all lanes SHALL be EMPTY and out_valid = 4'b0000.
REQ-030 While rst=1, rr_ptr SHALL be 0, xfer_cnt SHALL be 0, and out_data SHALL be all zeros.
REQ-031 Reset asserted mid-operation SHALL discard buffered words immediately, without waiting for a clock edge.
REQ-032 In the first cycle after reset release, in_ready SHALL be 1 for any target lane.

Structure
REQ-033 Package demux4_pkg SHALL hold LANES=4, LANE_IDX_W=2, the lane-state enum (EMPTY, FULL) and the mode encodings (MODE_SEL=0, MODE_RR=1).
REQ-034 Sub-module demux4_lane SHALL implement the one-entry buffer with load/drain and SHALL be instantiated 4 times.
REQ-035 Top level SHALL contain only target decode, in_ready mux, rr_ptr and xfer_cnt.

Verification
REQ-036 Reset, then mode=0, in_sel=2, in_data=0xA5, one-cycle in_valid -> next cycle out_valid=4'b0100, lane2 data=0xA5, xfer_cnt=1.
REQ-037 Mode=1, out_ready=4'b1111, 5 back-to-back words 0x10..0x14 -> lanes 0,1,2,3,0 receive them in order, rr_ptr ends at 1, in_ready stays 1.
REQ-038 Lane1 FULL, out_ready[1]=0, mode=0, in_sel=1, in_valid=1 -> in_ready=0, lane1 data unchanged, xfer_cnt unchanged.
REQ-039 Lane3 FULL with 0x33, out_ready[3]=1, new word 0x44 to lane3 in the same cycle -> in_ready=1, next cycle out_valid[3]=1 with data 0x44.
REQ-040 With 256 transfers -> xfer_cnt wraps to 0; rst pulsed between clock edges with lanes FULL -> out_valid=0 and rr_ptr=0 before the next edge.
